safe_code_sequencer: RTL and testbench

- Upstream feeder for the safe-check stage.
- Collects a CODE_LEN-character candidate code from a valid/ready character stream and replays it to the check stage as exactly CODE_LEN consecutive write strobes.
- Samples the check stage's open_safe result and reports pass/fail.
- Enforces a lockout after MAX_FAIL consecutive failed attempts.

---
 rtl/safe_code_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_safe_code_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/safe_code_sequencer.sv
// Collects a fixed-length code from a character stream, replays it to the safe-check
// stage as back-to-back write strobes, reports the result and enforces a failure lockout.
module safe_code_sequencer #(
    parameter int CODE_LEN     = 8,
    parameter int CHAR_W       = 7,
    parameter int MAX_FAIL     = 3,
    parameter int LOCK_CYCLES  = 1024,
    parameter int RESULT_DELAY = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_in_valid,
    input  logic [CHAR_W-1:0]               i_in_data,
    output logic                            o_in_ready,
    input  logic                            i_in_abort,
    output logic [CHAR_W-1:0]               o_chk_data,
    output logic                            o_chk_step,
    input  logic                            i_chk_open,
    output logic                            o_done,
    output logic                            o_pass,
    output logic                            o_locked,
    output logic [$clog2(MAX_FAIL+1)-1:0]   o_fail_count
);

    localparam int IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int DLY_W  = (RESULT_DELAY > 1) ? $clog2(RESULT_DELAY) : 1;
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_REPLAY,
        ST_WAIT,
        ST_REPORT,
        ST_LOCKOUT
    } state_t;

    state_t              r_state, w_stateNext;
    logic [IDX_W-1:0]    r_charCount, w_charCountNext;
    logic [IDX_W-1:0]    r_replayIdx, w_replayIdxNext;
    logic [IDX_W-1:0]    w_replayIdxInc;
    logic [DLY_W-1:0]    r_waitCnt, w_waitCntNext;
    logic [LOCK_W-1:0]   r_lockCnt, w_lockCntNext;
    logic [CHAR_W-1:0]   r_buf [CODE_LEN];
    logic                r_inReady, w_inReadyNext;
    logic [CHAR_W-1:0]   r_chkData, w_chkDataNext;
    logic                r_chkStep, w_chkStepNext;
    logic                r_done, w_doneNext;
    logic                r_pass, w_passNext;
    logic                r_locked, w_lockedNext;
    logic [FAIL_W-1:0]   r_failCount, w_failCountNext;
    logic                w_accept;
    logic [CHAR_W-1:0]   w_firstChar;

    assign w_accept       = (r_state == ST_COLLECT) && r_inReady && i_in_valid && !i_in_abort;
    assign w_replayIdxInc = r_replayIdx + IDX_W'(1);
    // With a one-character code the first replayed character is the one being accepted now
    assign w_firstChar    = (r_charCount == '0) ? i_in_data : r_buf[0];

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_buf[r_charCount] <= i_in_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_COLLECT;
            r_charCount <= '0;
            r_replayIdx <= '0;
            r_waitCnt   <= '0;
            r_lockCnt   <= '0;
            r_inReady   <= 1'b0;
            r_chkData   <= '0;
            r_chkStep   <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_locked    <= 1'b0;
            r_failCount <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_charCount <= w_charCountNext;
            r_replayIdx <= w_replayIdxNext;
            r_waitCnt   <= w_waitCntNext;
            r_lockCnt   <= w_lockCntNext;
            r_inReady   <= w_inReadyNext;
            r_chkData   <= w_chkDataNext;
            r_chkStep   <= w_chkStepNext;
            r_done      <= w_doneNext;
            r_pass      <= w_passNext;
            r_locked    <= w_lockedNext;
            r_failCount <= w_failCountNext;
        end
    end

    always_comb begin
        w_stateNext     = r_state;
        w_charCountNext = r_charCount;
        w_replayIdxNext = r_replayIdx;
        w_waitCntNext   = r_waitCnt;
        w_lockCntNext   = r_lockCnt;
        w_inReadyNext   = r_inReady;
        w_chkDataNext   = r_chkData;
        w_chkStepNext   = 1'b0;
        w_doneNext      = 1'b0;
        w_passNext      = r_pass;
        w_lockedNext    = r_locked;
        w_failCountNext = r_failCount;

        case (r_state)
            ST_COLLECT: begin
                w_inReadyNext = 1'b1;
                if (i_in_abort) begin
                    w_charCountNext = '0;
                end else if (w_accept) begin
                    if (r_charCount == IDX_W'(CODE_LEN - 1)) begin
                        w_charCountNext = '0;
                        w_inReadyNext   = 1'b0;
                        w_stateNext     = ST_REPLAY;
                        w_replayIdxNext = '0;
                        w_chkStepNext   = 1'b1;
                        w_chkDataNext   = w_firstChar;
                    end else begin
                        w_charCountNext = r_charCount + IDX_W'(1);
                    end
                end
            end

            // Replay always runs to completion so the check stage's write index wraps back
            ST_REPLAY: begin
                if (r_replayIdx == IDX_W'(CODE_LEN - 1)) begin
                    w_stateNext   = ST_WAIT;
                    w_waitCntNext = '0;
                end else begin
                    w_replayIdxNext = w_replayIdxInc;
                    w_chkStepNext   = 1'b1;
                    w_chkDataNext   = r_buf[w_replayIdxInc];
                end
            end

            ST_WAIT: begin
                if (r_waitCnt == DLY_W'(RESULT_DELAY - 1)) begin
                    w_stateNext = ST_REPORT;
                    w_doneNext  = 1'b1;
                    w_passNext  = i_chk_open;
                    if (i_chk_open) begin
                        w_failCountNext = '0;
                    end else if (r_failCount != FAIL_W'(MAX_FAIL)) begin
                        w_failCountNext = r_failCount + FAIL_W'(1);
                    end
                end else begin
                    w_waitCntNext = r_waitCnt + DLY_W'(1);
                end
            end

            ST_REPORT: begin
                if (!r_pass && (r_failCount == FAIL_W'(MAX_FAIL))) begin
                    w_stateNext   = ST_LOCKOUT;
                    w_lockedNext  = 1'b1;
                    w_lockCntNext = '0;
                end else begin
                    w_stateNext     = ST_COLLECT;
                    w_inReadyNext   = 1'b1;
                    w_charCountNext = '0;
                end
            end

            ST_LOCKOUT: begin
                if (r_lockCnt == LOCK_W'(LOCK_CYCLES - 1)) begin
                    w_stateNext     = ST_COLLECT;
                    w_lockedNext    = 1'b0;
                    w_failCountNext = '0;
                    w_inReadyNext   = 1'b1;
                    w_charCountNext = '0;
                end else begin
                    w_lockCntNext = r_lockCnt + LOCK_W'(1);
                end
            end

            default: begin
                w_stateNext = ST_COLLECT;
            end
        endcase
    end

    assign o_in_ready   = r_inReady;
    assign o_chk_data   = r_chkData;
    assign o_chk_step   = r_chkStep;
    assign o_done       = r_done;
    assign o_pass       = r_pass;
    assign o_locked     = r_locked;
    assign o_fail_count = r_failCount;

endmodule

// File: tb/tb_safe_code_sequencer.sv
// Directed bench for safe_code_sequencer: attempts, lockout, abort and mid-replay reset,
// with every expected value written out by hand.
module tb_safe_code_sequencer;

    logic       clk;
    logic       rst;
    logic       inValid;
    logic [6:0] inData;
    logic       inReady;
    logic       inAbort;
    logic [6:0] chkData;
    logic       chkStep;
    logic       chkOpen;
    logic       done;
    logic       pass;
    logic       locked;
    logic [1:0] failCount;

    int vectorCount = 0;
    int missCount   = 0;

    localparam logic [55:0] CODE_CTF  = {7'h43, 7'h54, 7'h46, 7'h7B, 7'h78, 7'h79, 7'h7A, 7'h7D};
    localparam logic [55:0] CODE_SAFE = {7'h73, 7'h61, 7'h66, 7'h65, 7'h31, 7'h32, 7'h33, 7'h34};
    localparam logic [55:0] CODE_BITS = {7'h00, 7'h7F, 7'h55, 7'h2A, 7'h01, 7'h40, 7'h7E, 7'h3F};

    safe_code_sequencer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_in_valid   (inValid),
        .i_in_data    (inData),
        .o_in_ready   (inReady),
        .i_in_abort   (inAbort),
        .o_chk_data   (chkData),
        .o_chk_step   (chkStep),
        .i_chk_open   (chkOpen),
        .o_done       (done),
        .o_pass       (pass),
        .o_locked     (locked),
        .o_fail_count (failCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tickCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [6:0] data, input logic abort);
        inValid = valid;
        inData  = data;
        inAbort = abort;
        tickCycle();
    endtask

    function automatic logic [6:0] charAt(input logic [55:0] code, input int idx);
        logic [55:0] shifted;
        shifted = code >> (7 * (7 - idx));
        return shifted[6:0];
    endfunction

    task automatic feedCode(input logic [55:0] code);
        for (int i = 0; i < 8; i++) begin
            checkOutput("inReadyCollect", 32'(inReady), 32'd1);
            applyStimulus(1'b1, charAt(code, i), 1'b0);
        end
        inValid = 1'b0;
        inData  = 7'h00;
    endtask

    // Starts with in_ready high; ends one cycle after the done pulse
    task automatic runAttempt(input logic [55:0] code, input logic openVal,
                              input logic [1:0] expFail, input logic expLock);
        feedCode(code);
        checkOutput("inReadyDrop", 32'(inReady), 32'd0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("replayStep", 32'(chkStep), 32'd1);
            checkOutput("replayData", 32'(chkData), 32'(charAt(code, k)));
            checkOutput("replayNoReady", 32'(inReady), 32'd0);
            tickCycle();
        end
        checkOutput("waitStepLow", 32'(chkStep), 32'd0);
        checkOutput("waitNoDone", 32'(done), 32'd0);
        checkOutput("waitDataHeld", 32'(chkData), 32'(charAt(code, 7)));
        chkOpen = openVal;
        tickCycle();
        chkOpen = 1'b0;
        checkOutput("donePulse", 32'(done), 32'd1);
        checkOutput("passValue", 32'(pass), 32'(openVal));
        checkOutput("failCount", 32'(failCount), 32'(expFail));
        checkOutput("reportStepLow", 32'(chkStep), 32'd0);
        tickCycle();
        checkOutput("doneOneCycle", 32'(done), 32'd0);
        checkOutput("lockedAfter", 32'(locked), 32'(expLock));
        checkOutput("readyAfter", 32'(inReady), 32'(!expLock));
    endtask

    initial begin
        int badCycles;
        rst     = 1'b1;
        inValid = 1'b0;
        inData  = 7'h00;
        inAbort = 1'b0;
        chkOpen = 1'b0;
        tickCycle();
        tickCycle();
        checkOutput("rstReady", 32'(inReady), 32'd0);
        checkOutput("rstStep", 32'(chkStep), 32'd0);
        checkOutput("rstData", 32'(chkData), 32'd0);
        checkOutput("rstDone", 32'(done), 32'd0);
        checkOutput("rstPass", 32'(pass), 32'd0);
        checkOutput("rstLocked", 32'(locked), 32'd0);
        checkOutput("rstFail", 32'(failCount), 32'd0);
        rst = 1'b0;
        tickCycle();
        checkOutput("readyAfterRst", 32'(inReady), 32'd1);

        $display("[TB] passing attempt with CTF{xyz}");
        runAttempt(CODE_CTF, 1'b1, 2'd0, 1'b0);

        $display("[TB] three failures into lockout");
        runAttempt(CODE_CTF, 1'b0, 2'd1, 1'b0);
        runAttempt(CODE_SAFE, 1'b0, 2'd2, 1'b0);
        runAttempt(CODE_CTF, 1'b0, 2'd3, 1'b1);
        badCycles = 0;
        for (int c = 0; c < 1024; c++) begin
            if (locked !== 1'b1 || inReady !== 1'b0 || chkStep !== 1'b0 || done !== 1'b0)
                badCycles++;
            applyStimulus(1'b1, 7'(c), c[3]);
        end
        inValid = 1'b0;
        inAbort = 1'b0;
        checkOutput("lockHeld1024", 32'(badCycles), 32'd0);
        checkOutput("lockReleased", 32'(locked), 32'd0);
        checkOutput("lockFailClear", 32'(failCount), 32'd0);
        checkOutput("lockReady", 32'(inReady), 32'd1);
        runAttempt(CODE_BITS, 1'b1, 2'd0, 1'b0);

        $display("[TB] two failures then a pass");
        runAttempt(CODE_SAFE, 1'b0, 2'd1, 1'b0);
        runAttempt(CODE_SAFE, 1'b0, 2'd2, 1'b0);
        runAttempt(CODE_SAFE, 1'b1, 2'd0, 1'b0);

        $display("[TB] abort after five characters");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, charAt(CODE_CTF, i), 1'b0);
        applyStimulus(1'b1, 7'h55, 1'b1);
        inValid = 1'b0;
        inAbort = 1'b0;
        checkOutput("abortReady", 32'(inReady), 32'd1);
        checkOutput("abortNoStep", 32'(chkStep), 32'd0);
        runAttempt(CODE_BITS, 1'b0, 2'd1, 1'b0);

        $display("[TB] reset on the fourth replay cycle");
        feedCode(CODE_SAFE);
        tickCycle();
        tickCycle();
        tickCycle();
        checkOutput("midReplayStep", 32'(chkStep), 32'd1);
        checkOutput("midReplayData", 32'(chkData), 32'(charAt(CODE_SAFE, 3)));
        rst = 1'b1;
        tickCycle();
        checkOutput("midRstStep", 32'(chkStep), 32'd0);
        checkOutput("midRstReady", 32'(inReady), 32'd0);
        checkOutput("midRstFail", 32'(failCount), 32'd0);
        rst = 1'b0;
        tickCycle();
        checkOutput("midRstReadyBack", 32'(inReady), 32'd1);
        badCycles = 0;
        for (int c = 0; c < 4; c++) begin
            if (done !== 1'b0 || chkStep !== 1'b0) badCycles++;
            tickCycle();
        end
        checkOutput("midRstNoDone", 32'(badCycles), 32'd0);
        runAttempt(CODE_CTF, 1'b1, 2'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
